// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register: one-slot EMPTY/FULL FSM with flush > stall > load priority.
// Optional performance counters (br_taken_cnt, bubble_cnt) are built only when EX_MEM_PERF_CNT_EN is defined.
module ex_mem_reg #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            flush,
    input  logic            ex_valid,
    input  logic [XLEN-1:0] ex_result,
    input  logic            ex_zero,
    input  logic [XLEN-1:0] ex_branch_target,
    input  logic [XLEN-1:0] ex_rs2_data,
    input  logic [4:0]      ex_rd,
    input  logic            ex_regwrite,
    input  logic            ex_memread,
    input  logic            ex_memwrite,
    input  logic            ex_memtoreg,
    input  logic            ex_branch,
    output logic            mem_valid,
    output logic [XLEN-1:0] mem_result,
    output logic            mem_zero,
    output logic [XLEN-1:0] mem_branch_target,
    output logic [XLEN-1:0] mem_rs2_data,
    output logic [4:0]      mem_rd,
    output logic            mem_regwrite,
    output logic            mem_memread,
    output logic            mem_memwrite,
    output logic            mem_memtoreg,
    output logic            mem_branch,
    output logic            pc_src
`ifdef EX_MEM_PERF_CNT_EN
    ,
    output logic [31:0]     br_taken_cnt,
    output logic [31:0]     bubble_cnt
`endif
);

    // state | meaning
    // EMPTY | slot holds a bubble, all control outputs 0
    // FULL  | slot holds a real instruction
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_state_t;

    slot_state_t state_q, state_d;
    logic        load_data;
    logic        ctrl_en;
    logic [4:0]  ctrl_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= EMPTY;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        load_data = 1'b0;
        ctrl_en   = 1'b0;
        ctrl_d    = 5'b0;
        if (flush) begin
            // Bubble only clears control; data is left as it was.
            state_d = EMPTY;
            ctrl_en = 1'b1;
        end else if (!stall) begin
            load_data = 1'b1;
            ctrl_en   = 1'b1;
            if (ex_valid) begin
                state_d = FULL;
                ctrl_d  = {ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_branch};
            end else begin
                state_d = EMPTY;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_result        <= '0;
            mem_zero          <= 1'b0;
            mem_branch_target <= '0;
            mem_rs2_data      <= '0;
            mem_rd            <= 5'd0;
        end else if (load_data) begin
            mem_result        <= ex_result;
            mem_zero          <= ex_zero;
            mem_branch_target <= ex_branch_target;
            mem_rs2_data      <= ex_rs2_data;
            mem_rd            <= ex_rd;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            {mem_regwrite, mem_memread, mem_memwrite, mem_memtoreg, mem_branch} <= 5'b0;
        end else if (ctrl_en) begin
            {mem_regwrite, mem_memread, mem_memwrite, mem_memtoreg, mem_branch} <= ctrl_d;
        end
    end

    assign mem_valid = (state_q == FULL);
    assign pc_src    = mem_valid & mem_branch & mem_zero;

`ifdef EX_MEM_PERF_CNT_EN
    logic advance;
    assign advance = flush | ~stall;

    // A taken slot is counted once, when it leaves the stage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            br_taken_cnt <= 32'd0;
            bubble_cnt   <= 32'd0;
        end else begin
            if (advance && pc_src)
                br_taken_cnt <= br_taken_cnt + 32'd1;
            if (advance && state_d == EMPTY)
                bubble_cnt <= bubble_cnt + 32'd1;
        end
    end
`endif

endmodule
